// File: rtl/blink_pkg.sv
// Shared definitions for the blink-pattern link: slot timing, reference pattern
// and receiver FSM state encodings.
package blink_pkg;

    localparam int unsigned SLOT_CYCLES_DEF = 2097152;
    localparam logic [31:0] EXPECTED_DEF    = 32'b111000000000111000000000111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HALF    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/pin_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, followed by a rising-edge detector.
module pin_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/blink_pattern_rx.sv
// Receive side of the blink-pattern loopback: frames on a rise after an idle gap,
// samples every slot at its midpoint and tracks consecutive matches against EXPECTED.
module blink_pattern_rx
    import blink_pkg::*;
#(
    parameter int unsigned          SLOT_CYCLES    = SLOT_CYCLES_DEF,
    parameter int unsigned          N_SLOTS        = 32,
    parameter int unsigned          MIN_IDLE_SLOTS = 4,
    parameter logic [N_SLOTS-1:0]   EXPECTED       = EXPECTED_DEF,
    parameter int unsigned          LOCK_FRAMES    = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               pin_i,
    output logic               frame_valid_o,
    output logic [N_SLOTS-1:0] frame_data_o,
    output logic               match_o,
    output logic               locked_o,
    output logic               led_o
);

    localparam int unsigned LOW_MAX = MIN_IDLE_SLOTS * SLOT_CYCLES;
    localparam int          LOW_W   = $clog2(LOW_MAX + 1);
    localparam int          TMR_W   = $clog2(SLOT_CYCLES);
    localparam int          BIT_W   = $clog2(N_SLOTS);
    localparam int          CNT_W   = $clog2(LOCK_FRAMES + 1);

    localparam logic [LOW_W-1:0] LOW_SAT  = LOW_W'(LOW_MAX);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(SLOT_CYCLES / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(SLOT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_FRAMES);

    logic               pin_level;
    logic               pin_rise;

    logic [1:0]         state_q,       state_d;
    logic [LOW_W-1:0]   low_run_q,     low_run_d;
    logic [TMR_W-1:0]   tmr_q,         tmr_d;
    logic [BIT_W-1:0]   bit_q,         bit_d;
    logic [N_SLOTS-1:0] shift_q,       shift_d;
    logic               frame_valid_q, frame_valid_d;
    logic [N_SLOTS-1:0] frame_data_q,  frame_data_d;
    logic               match_q,       match_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic               locked_q,      locked_d;
    logic [BIT_W-1:0]   next_bit;

    pin_sync_edge u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pin_i   (pin_i),
        .level_o (pin_level),
        .rise_o  (pin_rise)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            low_run_q     <= '0;
            tmr_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            match_q       <= 1'b0;
            cnt_q         <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            low_run_q     <= low_run_d;
            tmr_q         <= tmr_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            match_q       <= match_d;
            cnt_q         <= cnt_d;
            locked_q      <= locked_d;
        end
    end

    // low_run keeps counting mid-frame so the trailing low slots qualify the next start edge
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        frame_valid_d = 1'b0;
        frame_data_d  = frame_data_q;
        match_d       = match_q;
        cnt_d         = cnt_q;
        locked_d      = locked_q;
        next_bit      = bit_q + BIT_W'(1);

        if (pin_level) begin
            low_run_d = '0;
        end else if (low_run_q != LOW_SAT) begin
            low_run_d = low_run_q + LOW_W'(1);
        end else begin
            low_run_d = low_run_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pin_rise && (low_run_q == LOW_SAT)) begin
                    state_d = ST_HALF;
                    tmr_d   = TMR_HALF;
                    bit_d   = '0;
                end
            end
            ST_HALF: begin
                if (tmr_q == '0) begin
                    shift_d[0] = pin_level;
                    tmr_d      = TMR_FULL;
                    state_d    = ST_CAPTURE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (tmr_q == '0) begin
                    bit_d             = next_bit;
                    shift_d[next_bit] = pin_level;
                    tmr_d             = TMR_FULL;
                    if (next_bit == BIT_LAST) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                frame_valid_d = 1'b1;
                frame_data_d  = shift_q;
                match_d       = (shift_q == EXPECTED);
                if (shift_q == EXPECTED) begin
                    cnt_d = (cnt_q == CNT_LOCK) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
                locked_d = (cnt_d == CNT_LOCK);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_valid_o = frame_valid_q;
    assign frame_data_o  = frame_data_q;
    assign match_o       = match_q;
    assign locked_o      = locked_q;
    assign led_o         = locked_q;

endmodule
